nco_phase_to_amplitude: RTL

Pipelined phase-to-amplitude converter for the NCO, directly downstream of the phase accumulator. It takes the N-bit accumulated phase, optionally dithers it with an LFSR, and truncates it to P bits. It then produces signed sine and cosine samples from a single quarter-wave ROM using quadrant symmetry. Output is one sample per clock at fixed latency and feeds the DAC/mixer stages.

---
 rtl/nco_phase_to_amplitude.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nco_phase_to_amplitude.sv
// Phase-to-amplitude converter: optional LFSR dither, truncation to P bits, quarter-wave ROM folding.
// Four register stages, one sample per clock, no backpressure; bubbles hold the last output.
module nco_phase_to_amplitude #(
  parameter int N         = 32,
  parameter int P         = 10,
  parameter int W         = 12,
  parameter int DITHER_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        i_phase_in,
  input  logic                i_phase_valid,
  output logic signed [W-1:0] o_sine_out,
  output logic signed [W-1:0] o_cosine_out,
  output logic                o_out_valid
);

  localparam int A     = P - 2;
  localparam int DEPTH = 2 ** A;
  localparam int D     = ((N - P) < 16) ? (N - P) : 16;
  localparam logic [15:0] DMASK = 16'((32'd1 << D) - 32'd1);
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam longint TWO_PI_Q32 = 64'sd26986075410;

  // sin(2*pi*(k+0.5)/2^P) by Taylor series in Q30 fixed point, scaled and rounded.
  function automatic longint rom_val(input int k);
    longint x, x2, term, acc;
    x    = (TWO_PI_Q32 * longint'(2 * k + 1)) >>> (P + 1);
    x    = x >>> 2;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 10; n++) begin
      term = ((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      term = -term;
      acc  = acc + term;
    end
    return (acc * longint'(2 ** (W - 1) - 1) + (64'sd1 <<< 29)) >>> 30;
  endfunction

  logic [W-1:0] w_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [W-1:0] TK = W'(rom_val(k));
    assign w_rom[k] = TK;
  end

  logic [15:0]  r_lfsr;
  logic [N-1:0] w_dither;
  logic [P-1:0] w_pq;
  logic [1:0]   w_q;
  logic [A-1:0] w_i;

  logic         r_v1, r_v2, r_v3;
  logic [P-1:0] r_pq;
  logic [A-1:0] r_sin_addr, r_cos_addr;
  logic         r_sin_neg2, r_cos_neg2, r_sin_neg3, r_cos_neg3;
  logic [W-1:0] r_sin_mag, r_cos_mag;

  always_comb begin
    w_dither = '0;
    if (DITHER_EN != 0) w_dither = N'(r_lfsr & DMASK);
    w_pq = P'((i_phase_in + w_dither) >> (N - P));
    w_q  = r_pq[P-1:P-2];
    w_i  = r_pq[A-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED;
    end else if (i_phase_valid) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
    end
  end

  // Valid bits always advance; data registers load only behind a valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      o_out_valid <= 1'b0;
    end else begin
      r_v1 <= i_phase_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      o_out_valid <= r_v3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pq <= '0;
    end else if (i_phase_valid) begin
      r_pq <= w_pq;
    end
  end

  // Odd quadrants mirror the index; sine negates in the lower half-plane, cosine in q1/q2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sin_addr <= '0;
      r_cos_addr <= '0;
      r_sin_neg2 <= 1'b0;
      r_cos_neg2 <= 1'b0;
    end else if (r_v1) begin
      r_sin_addr <= w_q[0] ? ~w_i : w_i;
      r_cos_addr <= w_q[0] ? w_i : ~w_i;
      r_sin_neg2 <= w_q[1];
      r_cos_neg2 <= w_q[1] ^ w_q[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sin_mag  <= '0;
      r_cos_mag  <= '0;
      r_sin_neg3 <= 1'b0;
      r_cos_neg3 <= 1'b0;
    end else if (r_v2) begin
      r_sin_mag  <= w_rom[r_sin_addr];
      r_cos_mag  <= w_rom[r_cos_addr];
      r_sin_neg3 <= r_sin_neg2;
      r_cos_neg3 <= r_cos_neg2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_sine_out   <= '0;
      o_cosine_out <= '0;
    end else if (r_v3) begin
      o_sine_out   <= r_sin_neg3 ? -r_sin_mag : r_sin_mag;
      o_cosine_out <= r_cos_neg3 ? -r_cos_mag : r_cos_mag;
    end
  end

endmodule
